// File: rtl/digit_counter_nd.sv
// Multi-digit up/down counter, hex or BCD per digit, with load, tc and wrap.
// Digit 0 is the least significant nibble; tc cascades to a following stage.
module digit_counter_nd #(
    parameter int NDIGITS = 4,
    localparam int W = 4 * NDIGITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         bcd_mode,
    output logic [W-1:0] digits,
    output logic         tc,
    output logic         wrap
);

    logic [3:0]   dmax;
    logic [W-1:0] nxt_inc;
    logic [W-1:0] nxt_dec;
    logic [W-1:0] load_fix;
    logic         tc_up;
    logic         tc_dn;

    assign dmax = bcd_mode ? 4'd9 : 4'd15;

    // Ripple carry/borrow across digits in one cycle.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        logic [3:0] e;
        logic [3:0] l;
        nxt_inc  = '0;
        nxt_dec  = '0;
        load_fix = '0;
        tc_up    = 1'b1;
        tc_dn    = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        for (int k = 0; k < NDIGITS; k++) begin
            d = digits[4*k +: 4];
            e = (bcd_mode && d > 4'd9) ? 4'd9 : d;
            l = load_val[4*k +: 4];
            load_fix[4*k +: 4] = (bcd_mode && l > 4'd9) ? 4'd9 : l;
            tc_up = tc_up & (d >= dmax);
            tc_dn = tc_dn & (d == 4'd0);
            if (carry) begin
                if (e == dmax) begin
                    nxt_inc[4*k +: 4] = 4'd0;
                end else begin
                    nxt_inc[4*k +: 4] = e + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                nxt_inc[4*k +: 4] = d;
            end
            if (borrow) begin
                if (e == 4'd0) begin
                    nxt_dec[4*k +: 4] = dmax;
                end else begin
                    nxt_dec[4*k +: 4] = e - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                nxt_dec[4*k +: 4] = d;
            end
        end
    end

    assign tc = up ? tc_up : tc_dn;

    always_ff @(posedge clk) begin
        if (reset) begin
            digits <= '0;
            wrap   <= 1'b0;
        end else if (load) begin
            digits <= load_fix;
            wrap   <= 1'b0;
        end else if (en) begin
            digits <= up ? nxt_inc : nxt_dec;
            wrap   <= tc;
        end else begin
            wrap   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_counter_nd.sv
// Bench for digit_counter_nd: directed literal cases plus randomized
// traffic compared every cycle against a value-level reference model.
module tb_digit_counter_nd;

    localparam int ND = 4;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         bcd_mode = 1'b0;
    logic [W-1:0] digits;
    logic         tc;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_val;
    logic         m_wrap;
    bit           m_valid = 1'b0;

    digit_counter_nd #(.NDIGITS(ND)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up),
        .load(load), .load_val(load_val), .bcd_mode(bcd_mode),
        .digits(digits), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int dm(input logic bcd);
        return bcd ? 9 : 15;
    endfunction

    function automatic logic m_tc(input logic [W-1:0] v, input logic u,
                                  input logic bcd);
        logic r;
        if (!u) return (v == '0);
        r = 1'b1;
        for (int k = 0; k < ND; k++)
            if (int'(v[4*k +: 4]) < dm(bcd)) r = 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] m_clamp(input logic [W-1:0] v,
                                             input logic bcd);
        logic [W-1:0] r;
        r = v;
        if (bcd)
            for (int k = 0; k < ND; k++)
                if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
        return r;
    endfunction

    // Hex is plain modular arithmetic; BCD walks digits as decimal places.
    function automatic logic [W-1:0] m_step(input logic [W-1:0] v,
                                            input logic u, input logic bcd);
        int dig [ND];
        logic [W-1:0] r;
        int k;
        if (!bcd) return u ? v + 1'b1 : v - 1'b1;
        for (int i = 0; i < ND; i++) dig[i] = int'(v[4*i +: 4]);
        k = 0;
        while (k < ND) begin
            int x;
            x = (dig[k] > 9) ? 9 : dig[k];
            if (u) dig[k] = (x == 9) ? 0 : x + 1;
            else   dig[k] = (x == 0) ? 9 : x - 1;
            if ((u && x != 9) || (!u && x != 0)) break;
            k++;
        end
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(dig[i]);
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_val = '0; m_wrap = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (load) begin
                m_val = m_clamp(load_val, bcd_mode); m_wrap = 1'b0;
            end else if (en) begin
                m_wrap = m_tc(m_val, up, bcd_mode);
                m_val  = m_step(m_val, up, bcd_mode);
            end else begin
                m_wrap = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model digits", digits, m_val);
            check("model wrap", W'(wrap), W'(m_wrap));
            check("model tc", W'(tc), W'(m_tc(m_val, up, bcd_mode)));
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset then BCD count up 10 steps
        reset = 1'b1; up = 1'b0; cyc();
        check("reset digits", digits, '0);
        check("reset wrap", W'(wrap), '0);
        check("reset tc dn", W'(tc), W'(1));
        reset = 1'b0; bcd_mode = 1'b1; up = 1'b1; en = 1'b1;
        repeat (10) cyc();
        check("bcd 10 steps", digits, 16'h0010);
        // 2: BCD rollover
        en = 1'b0; load = 1'b1; load_val = 16'h9999; cyc();
        load = 1'b0;
        check("load 9999", digits, 16'h9999);
        check("tc at 9999", W'(tc), W'(1));
        en = 1'b1; cyc();
        check("bcd wrap digits", digits, 16'h0000);
        check("bcd wrap pulse", W'(wrap), W'(1));
        cyc();
        check("wrap one cycle", W'(wrap), W'(0));
        check("after wrap", digits, 16'h0001);
        // 3: hex rollover
        bcd_mode = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'hFFFE; cyc();
        load = 1'b0; en = 1'b1; cyc();
        check("hex FFFF", digits, 16'hFFFF);
        check("hex tc", W'(tc), W'(1));
        cyc();
        check("hex wrap digits", digits, 16'h0000);
        check("hex wrap pulse", W'(wrap), W'(1));
        // 4: BCD count down from zero
        reset = 1'b1; bcd_mode = 1'b1; up = 1'b0; en = 1'b0; cyc();
        reset = 1'b0;
        check("tc at zero dn", W'(tc), W'(1));
        en = 1'b1; cyc();
        check("dn wrap digits", digits, 16'h9999);
        check("dn wrap pulse", W'(wrap), W'(1));
        // 5: clamp on BCD load
        en = 1'b0; load = 1'b1; load_val = 16'h1A2F; cyc();
        load = 1'b0;
        check("bcd load clamp", digits, 16'h1929);
        up = 1'b1; en = 1'b1; cyc();
        check("step after clamp", digits, 16'h1930);
        // 6: priority
        reset = 1'b1; load = 1'b1; en = 1'b1; load_val = 16'h1234; cyc();
        check("reset wins", digits, 16'h0000);
        check("reset wins wrap", W'(wrap), W'(0));
        reset = 1'b0; cyc();
        check("load beats en", digits, 16'h1234);
        check("load no wrap", W'(wrap), W'(0));
        load = 1'b0; en = 1'b0;
        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 31) == 0) bcd_mode = ~bcd_mode;
            case ($urandom_range(0, 3))
                0: load_val = 16'hFFFF - W'($urandom_range(0, 3));
                1: load_val = 16'h9999 - W'($urandom_range(0, 3));
                2: load_val = W'($urandom_range(0, 3));
                default: load_val = W'($urandom);
            endcase
            cyc();
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
